// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   Req_i/WE_i/Addr_i/WData_i/ByteEn_i   core request (load or store)
//   Flush_i            single-cycle pulse invalidating every line
//   RData_o            load data, meaningful when Req_i & ~WE_i & ~Stall_o
//   Stall_o            core must hold its request this cycle
//   MemReq_o/MemWE_o/MemAddr_o/MemWData_o/MemByteEn_o  backing-memory beat
//   MemAck_i/MemRData_i  beat completion and refill data
//   HitCount_o/MissCount_o  load hit/miss counters (wrap modulo 2^32)
//
// Handshake: a core request completes on the rising edge where
// Req_i=1 and Stall_o=0; while Stall_o=1 the core holds every request
// field stable. A memory beat completes on the rising edge where
// MemReq_o=1 and MemAck_i=1; MemAck_i is ignored while MemReq_o=0, and
// MemReq_o stays high across consecutive refill beats.
module dcache_dm #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Req_i,
    input  logic                    WE_i,
    input  logic [ADDR_WIDTH-1:0]   Addr_i,
    input  logic [DATA_WIDTH-1:0]   WData_i,
    input  logic [DATA_WIDTH/8-1:0] ByteEn_i,
    input  logic                    Flush_i,
    output logic [DATA_WIDTH-1:0]   RData_o,
    output logic                    Stall_o,
    output logic                    MemReq_o,
    output logic                    MemWE_o,
    output logic [ADDR_WIDTH-1:0]   MemAddr_o,
    output logic [DATA_WIDTH-1:0]   MemWData_o,
    output logic [DATA_WIDTH/8-1:0] MemByteEn_o,
    input  logic                    MemAck_i,
    input  logic [DATA_WIDTH-1:0]   MemRData_i,
    output logic [31:0]             HitCount_o,
    output logic [31:0]             MissCount_o
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int OFF    = BEAT_W + 2;
    localparam int TAG_W  = ADDR_WIDTH - OFF - IDX_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t state, state_nxt;

    logic [NUM_SETS-1:0]   valid;
    logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS*WORDS_PER_LINE];

    logic                       flush_pending;
    logic [BEAT_W-1:0]          beat;
    logic [ADDR_WIDTH-OFF-1:0]  line_num;   // line being refilled
    logic [ADDR_WIDTH-3:0]      wr_waddr;   // word address of the pending store
    logic [DATA_WIDTH-1:0]      wr_data;
    logic [BE_W-1:0]            wr_be;
    logic [31:0]                hit_cnt;
    logic [31:0]                miss_cnt;

    // Byte-offset bits of the core address carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Addr_i[1:0];

    // Core request decode.
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [BEAT_W-1:0] req_word;
    logic              req_hit;
    assign req_idx  = Addr_i[OFF+IDX_W-1:OFF];
    assign req_tag  = Addr_i[ADDR_WIDTH-1:OFF+IDX_W];
    assign req_word = Addr_i[OFF-1:2];
    assign req_hit  = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // Refill line decode.
    logic [IDX_W-1:0] ref_idx;
    logic [TAG_W-1:0] ref_tag;
    assign ref_idx = line_num[IDX_W-1:0];
    assign ref_tag = line_num[ADDR_WIDTH-OFF-1:IDX_W];

    // Pending store decode; the hit is re-evaluated in the ack cycle so a
    // flush that happened meanwhile suppresses the cache update.
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic [BEAT_W-1:0] wr_word;
    logic              wr_hit;
    assign wr_word = wr_waddr[BEAT_W-1:0];
    assign wr_idx  = wr_waddr[BEAT_W+IDX_W-1:BEAT_W];
    assign wr_tag  = wr_waddr[ADDR_WIDTH-3:BEAT_W+IDX_W];
    assign wr_hit  = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    assign RData_o     = data_mem[{req_idx, req_word}];
    assign HitCount_o  = hit_cnt;
    assign MissCount_o = miss_cnt;

    logic last_ack;
    assign last_ack = MemAck_i && (beat == LAST_BEAT);

    // Next state and outputs.
    always_comb begin
        state_nxt   = state;
        Stall_o     = 1'b0;
        MemReq_o    = 1'b0;
        MemWE_o     = 1'b0;
        MemAddr_o   = '0;
        MemWData_o  = '0;
        MemByteEn_o = '0;
        case (state)
            IDLE: begin
                if (Req_i) begin
                    if (WE_i) begin
                        Stall_o   = 1'b1;
                        state_nxt = WRITE;
                    end else if (!req_hit) begin
                        Stall_o   = 1'b1;
                        state_nxt = REFILL;
                    end
                end
            end
            REFILL: begin
                Stall_o   = 1'b1;
                MemReq_o  = 1'b1;
                MemAddr_o = {line_num, beat, 2'b00};
                if (last_ack) state_nxt = IDLE;
            end
            WRITE: begin
                Stall_o     = ~MemAck_i;
                MemReq_o    = 1'b1;
                MemWE_o     = 1'b1;
                MemAddr_o   = {wr_waddr, 2'b00};
                MemWData_o  = wr_data;
                MemByteEn_o = wr_be;
                if (MemAck_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, valid bits and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            flush_pending <= 1'b0;
            beat          <= '0;
            line_num      <= '0;
            wr_waddr      <= '0;
            wr_data       <= '0;
            wr_be         <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (Req_i && !WE_i && req_hit) hit_cnt <= hit_cnt + 32'd1;
                    if (Req_i && !WE_i && !req_hit) begin
                        miss_cnt         <= miss_cnt + 32'd1;
                        valid[req_idx]   <= 1'b0;
                        beat             <= '0;
                        line_num         <= Addr_i[ADDR_WIDTH-1:OFF];
                    end
                    if (Req_i && WE_i) begin
                        wr_waddr <= Addr_i[ADDR_WIDTH-1:2];
                        wr_data  <= WData_i;
                        wr_be    <= ByteEn_i;
                    end
                    // The request above was decoded against the pre-flush
                    // valid bits; this whole-vector clear overrides them.
                    if (Flush_i) valid <= '0;
                end
                REFILL: begin
                    if (MemAck_i) beat <= beat + 1'b1;
                    if (last_ack) begin
                        if (flush_pending || Flush_i) valid <= '0;
                        else                          valid[ref_idx] <= 1'b1;
                        flush_pending <= 1'b0;
                    end else if (Flush_i) begin
                        flush_pending <= 1'b1;
                    end
                end
                WRITE: begin
                    if (MemAck_i) begin
                        if (flush_pending || Flush_i) valid <= '0;
                        flush_pending <= 1'b0;
                    end else if (Flush_i) begin
                        flush_pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays; guarded by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (state == REFILL && MemAck_i) begin
            data_mem[{ref_idx, beat}] <= MemRData_i;
            if (beat == LAST_BEAT) tag_mem[ref_idx] <= ref_tag;
        end
        if (state == WRITE && MemAck_i && wr_hit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) data_mem[{wr_idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Parametrised direct-mapped, write-through, no-write-allocate data cache between the core's memory stage and a word-wide backing memory. Read hits return data combinationally in the request cycle. Read misses stall the core while a line-refill state machine fetches the whole line. Writes are always forwarded to memory, and they update the cached copy only on a hit.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; a multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- NUM_SETS, 16, number of lines; a power of 2 and at least 2.
- WORDS_PER_LINE, 4, words per line; a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Req_i  in  1  core access request; the core holds Req_i, WE_i, Addr_i, WData_i and ByteEn_i stable while Stall_o=1.
- WE_i  in  1  1=store, 0=load.
- Addr_i  in  ADDR_WIDTH  byte address; bits [1:0] are ignored (word-granular).
- WData_i  in  DATA_WIDTH  store data.
- ByteEn_i  in  DATA_WIDTH/8  store byte enables.
- Flush_i  in  1  single-cycle pulse that invalidates all lines.
- RData_o  out  DATA_WIDTH  load data; valid when Req_i=1, WE_i=0 and Stall_o=0.
- Stall_o  out  1  core must hold its request this cycle.
- MemReq_o  out  1  memory beat request.
- MemWE_o  out  1  memory beat is a write.
- MemAddr_o  out  ADDR_WIDTH  word-aligned beat address.
- MemWData_o  out  DATA_WIDTH  write data.
- MemByteEn_o  out  DATA_WIDTH/8  write byte enables.
- MemAck_i  in  1  beat complete; read data is valid on MemRData_i in the same cycle.
- MemRData_i  in  DATA_WIDTH  refill data.
- HitCount_o  out  32  load hits, wraps modulo 2^32.
- MissCount_o  out  32  load misses, wraps modulo 2^32.

## Operation
Address split:
- OFF = log2(WORDS_PER_LINE)+2.
- IDX = log2(NUM_SETS), taken from bits [OFF+IDX-1:OFF].
- TAG = ADDR_WIDTH-OFF-IDX, the upper bits.
- Each line has a valid bit, a tag and WORDS_PER_LINE data words.
- Hit = valid[idx] and tag[idx]==Addr_i tag.

FSM states: IDLE, REFILL, WRITE.
- IDLE, load hit: RData_o = line word; Stall_o=0; HitCount_o increments.
- IDLE, load miss: Stall_o=1.
  - MissCount_o increments once.
  - valid[idx] is cleared at the edge.
  - Beat counter is set to 0 and the line base address is latched; next state is REFILL.
- IDLE, store (hit or miss): Stall_o=1.
  - Address, data and byte enables are latched; next state is WRITE.
- REFILL: MemReq_o=1, MemWE_o=0, MemAddr_o = base + 4*beat.
  - On each MemAck_i, MemRData_i is written to word[beat] and beat increments.
  - On the ack of the last beat, tag[idx] is written and valid[idx] is set (unless a flush is pending); next state is IDLE.
  - Stall_o=1 throughout REFILL. The core's held load hits in the following IDLE cycle and counts as a hit.
- WRITE: MemReq_o=1, MemWE_o=1, with the latched address, data and byte enables.
  - Stall_o = ~MemAck_i.
  - On the ack, if the latched address hits, the cached word is merged per byte enable; the line is never allocated on a store miss.
  - Next state is IDLE.
- Flush_i in IDLE: all valid bits clear at the edge. A request in the same cycle is evaluated against the pre-flush state and proceeds normally.
- Flush_i in REFILL or WRITE: sets flush_pending.
  - In REFILL, the refilled line is not marked valid.
  - All valid bits clear on the edge that returns to IDLE, and flush_pending clears.

## Timing
- Reset values:
  - state = IDLE; all valid bits = 0; flush_pending = 0; beat = 0.
  - MemReq_o = 0, MemWE_o = 0, Stall_o = Req_i (reflecting the empty cache).
  - HitCount_o = 0, MissCount_o = 0.
  - MemAddr_o, MemWData_o and MemByteEn_o = 0.
- Reset asserted mid-REFILL or mid-WRITE aborts the transaction: MemReq_o drops immediately and the partial line stays invalid.
- Latencies:
  - Load hit: 0 cycles.
  - Load miss: 1 + sum of per-beat latencies, plus 1 cycle for the re-presented hit.
  - Store: 1 + beat latency. The core advances in the ack cycle.
- MemReq_o stays high across back-to-back refill beats. MemAck_i is sampled only while MemReq_o=1.
- Only one transaction is outstanding at a time; no request is accepted outside IDLE.

## Test plan
Bench configuration: NUM_SETS=16, WORDS_PER_LINE=4; the memory model acks 2 cycles after each request beat; mem[a] = a ^ 0xA5A5_0000.

- Cold load miss then hit: after reset, load 0x100.
  - Beats go to 0x100, 0x104, 0x108, 0x10C; Stall_o is high for 9 cycles.
  - Next cycle RData_o = 0xA5A5_0100, Stall_o=0; MissCount_o=1, HitCount_o=1.
- Same-line hit: load 0x10C right after.
  - No MemReq_o; RData_o = 0xA5A5_010C in the same cycle; HitCount_o=2.
- Conflict eviction: load 0x100, then 0x500 (same index 0, different tag), then 0x100.
  - Three refills occur; MissCount_o=3.
- Store byte hit, then store miss:
  - Store 0x0000AB00 with ByteEn=0010 to 0x104: one memory write beat with ByteEn 0010. A subsequent load of 0x104 returns 0xA5A5AB04.
  - Store to 0x900 (uncached): one write beat, no refill. A load of 0x900 then misses.
- Flush during refill: pulse Flush_i during beat 2 of a refill of 0x200.
  - The refill completes, then the held load misses again and refetches.
  - After that second refill, the load hits.
- Reset mid-refill: assert rst during beat 1 of a refill of 0x300.
  - MemReq_o goes 0 asynchronously and counters read 0.
  - After release, a load of 0x300 misses.
